// File: rtl/blk_2c96b5_pkg.sv
// Package for the gate2 secure scan-mux select control segment.
// Provides the lock-state encoding and the default key/lockout parameters.
package blk_2c96b5_pkg;

  // Encoding 2'b11 is deliberately left out; the top treats it as a fault.
  typedef enum logic [1:0] {
    LsLocked   = 2'b00,
    LsUnlocked = 2'b01,
    LsLockout  = 2'b10
  } lock_state_e;

  localparam int unsigned DefKeyWidth = 16;
  localparam logic [15:0] DefKeyValue = 16'hA5C3;
  localparam int unsigned DefMaxFails = 3;

endpackage

// File: rtl/blk_2c96b5_tdr_shift_reg.sv
// Parameterized IJTAG TDR capture/shift register.
// Ports:
//   i_clk         IJTAG clock, rising edge
//   i_rst         asynchronous active-high reset, clears the register
//   i_capture_en  load i_capture_vec (wins over shift)
//   i_shift_en    shift one bit: i_si enters MSB, LSB leaves on o_so
//   i_capture_vec parallel capture value
//   i_si          scan in
//   o_so          scan out, always the register LSB
//   o_data        parallel register contents
module blk_2c96b5_tdr_shift_reg
  import blk_2c96b5_pkg::*;
#(
  parameter int unsigned Width = DefKeyWidth + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_capture_en,
  input  logic             i_shift_en,
  input  logic [Width-1:0] i_capture_vec,
  input  logic             i_si,
  output logic             o_so,
  output logic [Width-1:0] o_data
);

  logic [Width-1:0] r_sr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr <= '0;
    end else if (i_capture_en) begin
      r_sr <= i_capture_vec;
    end else if (i_shift_en) begin
      r_sr <= {i_si, r_sr[Width-1:1]};
    end
  end

  assign o_so   = r_sr[0];
  assign o_data = r_sr;

endmodule

// File: rtl/blk_2c96b5.sv
// Gate2 secure scan-mux select control segment (IJTAG TDR).
// A KEY_WIDTH+1 bit TDR holds {key, sel_req}. On update, a matching key
// unlocks the segment and loads mux select from sel_req; repeated mismatches
// push the block into a lockout that only reset clears.
// Ports:
//   i_ijtag_tck    IJTAG clock, all state on rising edge
//   i_ijtag_reset  asynchronous active-high reset
//   i_ijtag_sel    segment selected; gates ce/se/ue
//   i_ijtag_ce     capture enable (highest priority)
//   i_ijtag_se     shift enable
//   i_ijtag_ue     update enable (lowest priority)
//   i_ijtag_si     scan in
//   o_ijtag_so     scan out = sr[0]
//   o_mux_select   registered select to the scan mux
//   o_lock_state   00 locked, 01 unlocked, 10 lockout
//   o_fail_count   saturating mismatch count
module blk_2c96b5
  import blk_2c96b5_pkg::*;
#(
  parameter int unsigned            KEY_WIDTH = DefKeyWidth,
  parameter logic [KEY_WIDTH-1:0]   KEY_VALUE = DefKeyValue,
  parameter int unsigned            MAX_FAILS = DefMaxFails,
  localparam int unsigned           FCW       = $clog2(MAX_FAILS + 1)
) (
  input  logic           i_ijtag_tck,
  input  logic           i_ijtag_reset,
  input  logic           i_ijtag_sel,
  input  logic           i_ijtag_ce,
  input  logic           i_ijtag_se,
  input  logic           i_ijtag_ue,
  input  logic           i_ijtag_si,
  output logic           o_ijtag_so,
  output logic           o_mux_select,
  output logic [1:0]     o_lock_state,
  output logic [FCW-1:0] o_fail_count
);

  localparam int unsigned    SrWidth   = KEY_WIDTH + 1;
  localparam logic [FCW-1:0] MaxFailsW = FCW'(MAX_FAILS);

  lock_state_e    r_state;
  lock_state_e    w_state_d;
  logic           r_mux_select;
  logic           w_mux_select_d;
  logic [FCW-1:0] r_fail_count;
  logic [FCW-1:0] w_fail_count_d;
  logic [FCW-1:0] w_fail_inc;

  logic               w_capture;
  logic               w_shift;
  logic               w_update;
  logic [SrWidth-1:0] w_capture_vec;
  logic [SrWidth-1:0] w_sr;
  logic               w_match;

  // One action per cycle: capture beats shift beats update.
  assign w_capture = i_ijtag_sel & i_ijtag_ce;
  assign w_shift   = i_ijtag_sel & ~i_ijtag_ce & i_ijtag_se;
  assign w_update  = i_ijtag_sel & ~i_ijtag_ce & ~i_ijtag_se & i_ijtag_ue;

  assign w_capture_vec = {{(KEY_WIDTH - 2){1'b0}}, r_state, r_mux_select};

  blk_2c96b5_tdr_shift_reg #(
    .Width (SrWidth)
  ) u_tdr (
    .i_clk         (i_ijtag_tck),
    .i_rst         (i_ijtag_reset),
    .i_capture_en  (w_capture),
    .i_shift_en    (w_shift),
    .i_capture_vec (w_capture_vec),
    .i_si          (i_ijtag_si),
    .o_so          (o_ijtag_so),
    .o_data        (w_sr)
  );

  assign w_match = (w_sr[SrWidth-1:1] == KEY_VALUE);

  // Saturating increment: the count never wraps past MAX_FAILS.
  assign w_fail_inc = (r_fail_count >= MaxFailsW) ? MaxFailsW : r_fail_count + FCW'(1);

  always_comb begin
    w_state_d      = r_state;
    w_mux_select_d = r_mux_select;
    w_fail_count_d = r_fail_count;

    case (r_state)
      LsLocked: begin
        if (w_update) begin
          if (w_match) begin
            w_state_d      = LsUnlocked;
            w_mux_select_d = w_sr[0];
            w_fail_count_d = '0;
          end else begin
            w_fail_count_d = w_fail_inc;
            w_state_d      = (w_fail_inc >= MaxFailsW) ? LsLockout : LsLocked;
          end
        end
      end
      LsUnlocked: begin
        if (w_update) begin
          if (w_match) begin
            w_mux_select_d = w_sr[0];
          end else begin
            w_mux_select_d = 1'b0;
            w_fail_count_d = w_fail_inc;
            w_state_d      = (w_fail_inc >= MaxFailsW) ? LsLockout : LsLocked;
          end
        end
      end
      LsLockout: begin
        w_mux_select_d = 1'b0;
      end
      default: begin
        // Unreachable encoding: fail safe into lockout on the next edge.
        w_state_d      = LsLockout;
        w_mux_select_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_ijtag_tck or posedge i_ijtag_reset) begin
    if (i_ijtag_reset) begin
      r_state      <= LsLocked;
      r_mux_select <= 1'b0;
      r_fail_count <= '0;
    end else begin
      r_state      <= w_state_d;
      r_mux_select <= w_mux_select_d;
      r_fail_count <= w_fail_count_d;
    end
  end

  assign o_mux_select = r_mux_select;
  assign o_lock_state = r_state;
  assign o_fail_count = r_fail_count;

endmodule

// File: tb/tb_blk_2c96b5.sv
module tb_blk_2c96b5;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel, ce, se, ue, si;
  logic       so, mux_sel;
  logic [1:0] lock_state;
  logic [1:0] fail_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  blk_2c96b5 dut (
    .i_ijtag_tck   (clk),
    .i_ijtag_reset (rst),
    .i_ijtag_sel   (sel),
    .i_ijtag_ce    (ce),
    .i_ijtag_se    (se),
    .i_ijtag_ue    (ue),
    .i_ijtag_si    (si),
    .o_ijtag_so    (so),
    .o_mux_select  (mux_sel),
    .o_lock_state  (lock_state),
    .o_fail_count  (fail_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag, input logic m, input logic [1:0] st,
                          input logic [1:0] cnt);
    chk({tag, ".mux"}, 32'(mux_sel), 32'(m));
    chk({tag, ".state"}, 32'(lock_state), 32'(st));
    chk({tag, ".count"}, 32'(fail_count), 32'(cnt));
  endtask

  // Load {key, req}: req is shifted first so it ends up in sr[0].
  task automatic shift_in(input logic [15:0] key, input logic req);
    logic [16:0] v;
    v   = {key, req};
    sel = 1'b1;
    se  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      si = v[i];
      tick();
    end
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic do_update();
    sel = 1'b1;
    ue  = 1'b1;
    tick();
    ue  = 1'b0;
  endtask

  task automatic do_capture();
    sel = 1'b1;
    ce  = 1'b1;
    tick();
    ce  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    #2;
    chk_outs("reset", 1'b0, 2'b00, 2'd0);
    chk("reset.so", 32'(so), 32'd0);
    #2;
    rst = 1'b0;
    tick();

    // Capture in reset state gives all zeros; shifted-in ones reach so after 17.
    do_capture();
    chk("t1.cap_so", 32'(so), 32'd0);
    sel = 1'b1; se = 1'b1; si = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk("t1.so_16", 32'(so), 32'd0);
    tick();
    chk("t1.so_17", 32'(so), 32'd1);
    se = 1'b0; si = 1'b0;

    // Correct key with sel_req=1 unlocks.
    shift_in(16'hA5C3, 1'b1);
    chk("t2.so_req", 32'(so), 32'd1);
    chk_outs("t2.pre_update", 1'b0, 2'b00, 2'd0);
    do_update();
    chk_outs("t2.unlock", 1'b1, 2'b01, 2'd0);

    // Capture reflects {state=01, mux=1}: so stream 1,1,0.
    do_capture();
    chk("t2.cap_b0", 32'(so), 32'd1);
    se = 1'b1;
    tick();
    chk("t2.cap_b1", 32'(so), 32'd1);
    tick();
    chk("t2.cap_b2", 32'(so), 32'd0);
    se = 1'b0;

    // Deselected segment ignores all enables.
    shift_in(16'h0000, 1'b0);
    chk("t5.so_loaded", 32'(so), 32'd0);
    sel = 1'b0; si = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ce = i[0]; se = i[1]; ue = i[2];
      tick();
    end
    ce = 1'b0; se = 1'b0; ue = 1'b0;
    chk("t5.so_hold", 32'(so), 32'd0);
    chk_outs("t5.hold", 1'b1, 2'b01, 2'd0);
    // All enables with sel=1: capture only, the pending wrong key is not evaluated.
    sel = 1'b1; ce = 1'b1; se = 1'b1; ue = 1'b1;
    tick();
    ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    chk("t5.cap_so", 32'(so), 32'd1);
    chk_outs("t5.cap_only", 1'b1, 2'b01, 2'd0);

    // Wrong key from unlocked relocks.
    shift_in(16'h0000, 1'b1);
    do_update();
    chk_outs("t3.relock", 1'b0, 2'b00, 2'd1);

    // Three wrong keys from reset reach lockout.
    do_reset();
    chk_outs("t4.reset", 1'b0, 2'b00, 2'd0);
    shift_in(16'h1234, 1'b1);
    do_update();
    chk_outs("t4.fail1", 1'b0, 2'b00, 2'd1);
    shift_in(16'h1234, 1'b1);
    do_update();
    chk_outs("t4.fail2", 1'b0, 2'b00, 2'd2);
    shift_in(16'h1234, 1'b1);
    do_update();
    chk_outs("t4.fail3", 1'b0, 2'b10, 2'd3);
    shift_in(16'hA5C3, 1'b1);
    do_update();
    chk_outs("t4.lockout_key", 1'b0, 2'b10, 2'd3);
    shift_in(16'h1234, 1'b1);
    do_update();
    chk_outs("t4.saturate", 1'b0, 2'b10, 2'd3);
    do_reset();
    chk_outs("t4.reset_clear", 1'b0, 2'b00, 2'd0);

    // A locked match clears the fail count; sel_req=0 selects 0.
    shift_in(16'hFFFF, 1'b1);
    do_update();
    chk_outs("t4b.fail1", 1'b0, 2'b00, 2'd1);
    shift_in(16'hA5C3, 1'b0);
    do_update();
    chk_outs("t4b.unlock_req0", 1'b0, 2'b01, 2'd0);
    shift_in(16'hA5C3, 1'b1);
    do_update();
    chk_outs("t4b.unlocked_req1", 1'b1, 2'b01, 2'd0);

    // Asynchronous reset after 8 shifted bits; sr[0] is then key bit 7 (=1).
    sel = 1'b1; se = 1'b1; si = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t6.so_mid", 32'(so), 32'd1);
    rst = 1'b1;
    #1;
    chk_outs("t6.async", 1'b0, 2'b00, 2'd0);
    chk("t6.so_async", 32'(so), 32'd0);
    se  = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    do_capture();
    chk("t6.cap_so", 32'(so), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
